// File: rtl/edge_capture_bank.sv
// -----------------------------------------------------------------------------
// edge_capture_bank
//
// Multi-channel edge detector and capture register. Each event line is passed
// through a SYNC-deep synchroniser plus a history flop. A per-channel mode picks
// which transitions count as events. Each event does three things:
//   - fires a one-cycle strobe,
//   - captures the shared data bus into the channel's register,
//   - sets a sticky pending flag.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     synchronous, active-low reset
//   sig       [CH-1:0]    event lines, may be asynchronous to clk
//   mode      [2*CH-1:0]  per-channel edge select at [2i+1:2i]:
//                         00 off, 01 rising, 10 falling, 11 both
//   din       [W-1:0]     shared data bus, sampled when an edge is detected
//   clr       [CH-1:0]    per-channel clear of pending and overrun
//   pulse     [CH-1:0]    one-cycle strobe per detected edge
//   pending   [CH-1:0]    sticky "edge captured, not yet cleared"
//   overrun   [CH-1:0]    sticky "edge arrived while pending already set"
//   cap_data  [CH*W-1:0]  captured din, channel i at [W*i+W-1:W*i]
// -----------------------------------------------------------------------------
module edge_capture_bank #(
  parameter int CH   = 4,
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     sig,
  input  logic [2*CH-1:0]   mode,
  input  logic [W-1:0]      din,
  input  logic [CH-1:0]     clr,
  output logic [CH-1:0]     pulse,
  output logic [CH-1:0]     pending,
  output logic [CH-1:0]     overrun,
  output logic [CH*W-1:0]   cap_data
);

  // The synchroniser and history flops need SYNC+1 clocks after reset before
  // they reflect the real line level. Until then, a line that was already high
  // would look like a rising edge, so detection stays gated off.
  localparam int ARM_MAX = SYNC + 1;
  localparam int CW      = $clog2(ARM_MAX + 1);

  logic [CW-1:0] r_arm_cnt;
  logic          w_armed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_arm_cnt <= '0;
    end else if (r_arm_cnt != CW'(ARM_MAX)) begin
      r_arm_cnt <= r_arm_cnt + CW'(1);
    end
  end

  assign w_armed = (r_arm_cnt == CW'(ARM_MAX));

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC-1:0] r_sync;
      logic            r_hist;
      logic            w_rise;
      logic            w_fall;
      logic            w_edge;
      logic            r_pulse;
      logic            r_pending;
      logic            r_overrun;
      logic [W-1:0]    r_cap;

      assign w_rise = r_sync[SYNC-1] & ~r_hist;
      assign w_fall = ~r_sync[SYNC-1] & r_hist;

      // mode acts only as a mask on the transition terms. A mode change
      // therefore cannot produce an edge by itself.
      assign w_edge = w_armed & ((mode[2*gi] & w_rise) | (mode[2*gi+1] & w_fall));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_sync    <= '0;
          r_hist    <= 1'b0;
          r_pulse   <= 1'b0;
          r_pending <= 1'b0;
          r_overrun <= 1'b0;
          r_cap     <= '0;
        end else begin
          // The synchroniser and history flops keep tracking sig while the
          // channel is still disarmed.
          r_sync[0] <= sig[gi];
          for (int k = 1; k < SYNC; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
          r_hist  <= r_sync[SYNC-1];
          r_pulse <= w_edge;

          if (w_edge) begin
            // The latest event always wins the capture register.
            r_cap     <= din;
            r_pending <= 1'b1;
            // A clear in the same cycle consumes the older event, so no
            // overrun is recorded. Otherwise an edge on top of an
            // uncleared one is an overrun.
            if (clr[gi]) begin
              r_overrun <= 1'b0;
            end else if (r_pending) begin
              r_overrun <= 1'b1;
            end
          end else if (clr[gi]) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
          end
        end
      end

      assign pulse[gi]            = r_pulse;
      assign pending[gi]          = r_pending;
      assign overrun[gi]          = r_overrun;
      assign cap_data[W*gi +: W]  = r_cap;
    end
  endgenerate

endmodule

// File: tb/tb_edge_capture_bank.sv
// -----------------------------------------------------------------------------
// tb_edge_capture_bank
//
// Self-checking bench for edge_capture_bank (CH=4, W=8, SYNC=2). It runs in
// three parts:
//   1. A table of per-cycle vectors, each with hand-derived expected outputs.
//   2. Hand-written multi-cycle sequences with explicit checks.
//   3. Randomised traffic.
// Every cycle is also compared against a reference model. The model treats the
// synchroniser as a pure delay line of sampled sig values and applies the event
// rules directly.
// -----------------------------------------------------------------------------
module tb_edge_capture_bank;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int SYNC = 2;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     sig;
  logic [2*CH-1:0]   mode;
  logic [W-1:0]      din;
  logic [CH-1:0]     clr;
  logic [CH-1:0]     pulse;
  logic [CH-1:0]     pending;
  logic [CH-1:0]     overrun;
  logic [CH*W-1:0]   cap_data;

  edge_capture_bank #(.CH(CH), .W(W), .SYNC(SYNC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig      (sig),
    .mode     (mode),
    .din      (din),
    .clr      (clr),
    .pulse    (pulse),
    .pending  (pending),
    .overrun  (overrun),
    .cap_data (cap_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // samp[j] holds sig as sampled j+1 clock edges ago, counting only edges
  // since the last reset. The synchronised level is samp[SYNC-1] and the
  // history level is samp[SYNC].
  logic [CH-1:0]   samp [0:SYNC];
  int              since_rst;
  logic [CH-1:0]   m_pulse, m_pend, m_ovr;
  logic [CH*W-1:0] m_cap;

  task automatic model_edge(input logic r, input logic [CH-1:0] s,
                            input logic [2*CH-1:0] m, input logic [W-1:0] d,
                            input logic [CH-1:0] c);
    logic [CH-1:0] lvl, prev;
    bit armed, rise, fall, ev;
    if (!r) begin
      m_pulse = '0; m_pend = '0; m_ovr = '0; m_cap = '0;
      for (int j = 0; j <= SYNC; j++) samp[j] = '0;
      since_rst = 0;
    end else begin
      lvl   = samp[SYNC-1];
      prev  = samp[SYNC];
      armed = (since_rst >= SYNC + 1);
      for (int i = 0; i < CH; i++) begin
        rise = lvl[i] & ~prev[i];
        fall = ~lvl[i] & prev[i];
        ev   = armed && ((m[2*i] && rise) || (m[2*i+1] && fall));
        m_pulse[i] = ev;
        if (ev) begin
          m_ovr[i]          = c[i] ? 1'b0 : (m_ovr[i] | m_pend[i]);
          m_pend[i]         = 1'b1;
          m_cap[i*W +: W]   = d;
        end else if (c[i]) begin
          m_pend[i] = 1'b0;
          m_ovr[i]  = 1'b0;
        end
      end
      for (int j = SYNC; j > 0; j--) samp[j] = samp[j-1];
      samp[0] = s;
      since_rst++;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock transaction: drive the inputs, advance the model, sample the
  // DUT just after the edge and compare it against the model.
  task automatic step(input logic r, input logic [CH-1:0] s, input logic [2*CH-1:0] m,
                      input logic [W-1:0] d, input logic [CH-1:0] c, input string tag);
    rst_n = r; sig = s; mode = m; din = d; clr = c;
    model_edge(r, s, m, d, c);
    @(posedge clk); #1;
    chk({tag, ".pulse"},   64'(pulse),    64'(m_pulse));
    chk({tag, ".pending"}, 64'(pending),  64'(m_pend));
    chk({tag, ".overrun"}, 64'(overrun),  64'(m_ovr));
    chk({tag, ".cap"},     64'(cap_data), 64'(m_cap));
    $display("%s rst_n=%b sig=%b mode=%h din=%h clr=%b | pulse=%b pend=%b ovr=%b cap=%h",
             tag, r, s, m, d, c, pulse, pending, overrun, cap_data);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            r;
    logic [CH-1:0]   s;
    logic [2*CH-1:0] m;
    logic [W-1:0]    d;
    logic [CH-1:0]   c;
    logic [CH-1:0]   e_pulse;
    logic [CH-1:0]   e_pend;
    logic [CH-1:0]   e_ovr;
    logic [CH*W-1:0] e_cap;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [CH-1:0] s, logic [2*CH-1:0] m, logic [W-1:0] d,
                              logic [CH-1:0] c, logic [CH-1:0] ep, logic [CH-1:0] epd,
                              logic [CH-1:0] eo, logic [CH*W-1:0] ec);
    vec_t v;
    v.r = r; v.s = s; v.m = m; v.d = d; v.c = c;
    v.e_pulse = ep; v.e_pend = epd; v.e_ovr = eo; v.e_cap = ec;
    tbl.push_back(v);
  endfunction

  int              npulse;
  logic [CH-1:0]   s_cur;
  logic [CH-1:0]   pulse_or;
  logic [2*CH-1:0] m_rand;

  initial begin
    rst_n = 1'b0; sig = '0; mode = '0; din = '0; clr = '0;
    since_rst = 0;
    for (int j = 0; j <= SYNC; j++) samp[j] = '0;
    m_pulse = '0; m_pend = '0; m_ovr = '0; m_cap = '0;

    // Reset with all lines high, then release: arming must hide the level.
    add(0, 4'hF, 8'h55, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
    add(0, 4'hF, 8'h55, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 20; i++)
      add(1, 4'hF, 8'h55, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
    // Channel 0: fall (ignored by rising mode), then rise captures A5 on the third edge.
    for (int i = 0; i < 4; i++)
      add(1, 4'hE, 8'h55, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
    add(1, 4'hF, 8'h55, 8'hA5, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
    add(1, 4'hF, 8'h55, 8'hA5, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
    add(1, 4'hF, 8'h55, 8'hA5, 4'h0, 4'h1, 4'h1, 4'h0, 32'h0000_00A5);
    add(1, 4'hF, 8'h55, 8'h00, 4'h0, 4'h0, 4'h1, 4'h0, 32'h0000_00A5);
    for (int i = 0; i < 5; i++)
      add(1, 4'hE, 8'h55, 8'h00, 4'h0, 4'h0, 4'h1, 4'h0, 32'h0000_00A5);
    // Channel 2: edge and clear in the same cycle, then clear alone.
    for (int i = 0; i < 4; i++)
      add(1, 4'hA, 8'h55, 8'h00, 4'h0, 4'h0, 4'h1, 4'h0, 32'h0000_00A5);
    add(1, 4'hE, 8'h55, 8'h3C, 4'h0, 4'h0, 4'h1, 4'h0, 32'h0000_00A5);
    add(1, 4'hE, 8'h55, 8'h3C, 4'h0, 4'h0, 4'h1, 4'h0, 32'h0000_00A5);
    add(1, 4'hE, 8'h55, 8'h3C, 4'h4, 4'h4, 4'h5, 4'h0, 32'h003C_00A5);
    add(1, 4'hE, 8'h55, 8'h00, 4'h4, 4'h0, 4'h1, 4'h0, 32'h003C_00A5);
    add(1, 4'hE, 8'h55, 8'h00, 4'h0, 4'h0, 4'h1, 4'h0, 32'h003C_00A5);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].m, tbl[i].d, tbl[i].c, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_pulse", i),   64'(pulse),    64'(tbl[i].e_pulse));
      chk($sformatf("vec%0d.tbl_pending", i), 64'(pending),  64'(tbl[i].e_pend));
      chk($sformatf("vec%0d.tbl_overrun", i), 64'(overrun),  64'(tbl[i].e_ovr));
      chk($sformatf("vec%0d.tbl_cap", i),     64'(cap_data), 64'(tbl[i].e_cap));
    end

    // Channel 1 in both-edges mode, toggled every 4 cycles, four times.
    s_cur  = 4'hE;
    npulse = 0;
    for (int n = 0; n < 20; n++) begin
      if ((n % 4) == 0 && n < 16) s_cur[1] = ~s_cur[1];
      step(1, s_cur, 8'h5D, 8'(8'h40 + n), 4'h0, "toggle");
      if (pulse[1] === 1'b1) begin
        npulse++;
        chk("toggle.cap1", 64'(cap_data[15:8]), 64'(8'h40 + n));
        chk("toggle.ovr1", 64'(overrun[1]), 64'(npulse >= 2));
      end
    end
    chk("toggle.count", 64'(npulse), 64'd4);

    // Mixed modes 00/01/10/11 with simultaneous rising, then falling, edges.
    for (int n = 0; n < 5; n++) step(1, 4'h0, 8'hE4, 8'h00, 4'h0, "mixed");
    step(1, 4'h0, 8'hE4, 8'h00, 4'hF, "mixed");
    for (int n = 0; n < 3; n++) step(1, 4'hF, 8'hE4, 8'h77, 4'h0, "mixed_rise");
    chk("mixed.rise_pulse", 64'(pulse), 64'(4'b1010));
    chk("mixed.rise_pend",  64'(pending), 64'(4'b1010));
    chk("mixed.rise_cap",   64'({cap_data[31:24], cap_data[15:8]}), 64'(16'h7777));
    for (int n = 0; n < 3; n++) step(1, 4'hF, 8'hE4, 8'h00, 4'h0, "mixed");
    step(1, 4'hF, 8'hE4, 8'h00, 4'hF, "mixed");
    for (int n = 0; n < 3; n++) step(1, 4'h0, 8'hE4, 8'h88, 4'h0, "mixed_fall");
    chk("mixed.fall_pulse", 64'(pulse), 64'(4'b1100));
    chk("mixed.fall_cap",   64'(cap_data[31:8]), 64'(24'h8888_77));

    // Everything pending and overrun, then a one-cycle reset.
    for (int n = 0; n < 4; n++) step(1, 4'hF, 8'hFF, 8'h11, 4'h0, "ovr_fill");
    for (int n = 0; n < 4; n++) step(1, 4'h0, 8'hFF, 8'h22, 4'h0, "ovr_fill");
    chk("rst.pre_pend", 64'(pending), 64'(4'hF));
    chk("rst.pre_ovr",  64'(overrun), 64'(4'hF));
    step(0, 4'hF, 8'hFF, 8'h33, 4'h0, "midrst");
    chk("rst.flags", 64'({pulse, pending, overrun}), 64'(12'h000));
    chk("rst.cap",   64'(cap_data), 64'(32'h0));
    pulse_or = '0;
    for (int n = 0; n < 6; n++) begin
      step(1, 4'hF, 8'hFF, 8'h44, 4'h0, "rearm");
      pulse_or |= pulse;
    end
    chk("rearm.no_pulse", 64'(pulse_or), 64'(4'h0));
    for (int n = 0; n < 3; n++) step(1, 4'h0, 8'hFF, 8'h55, 4'h0, "rearm_fall");
    chk("rearm.fall_pulse", 64'(pulse), 64'(4'hF));
    chk("rearm.fall_cap",   64'(cap_data), 64'(32'h5555_5555));

    // Randomised traffic against the model.
    s_cur  = 4'h0;
    m_rand = 8'hFF;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(3) == 0) s_cur[i] = ~s_cur[i];
      if ($urandom_range(15) == 0) m_rand = 8'($urandom);
      step(($urandom_range(149) != 0), s_cur, m_rand, 8'($urandom),
           4'($urandom & $urandom & $urandom), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_capture_bank.md
# edge_capture_bank

Parametrised multi-channel edge detector and capture register, the clocked successor to the gate-level pulse-transition-detector latch.
- Each of CH input lines is synchronised and edge-detected according to a per-channel mode.
- Each detected edge produces a one-cycle pulse, captures the shared data bus into that channel's register, and sets a sticky pending flag.
- Sits between slow or asynchronous event lines and the rest of the synchronous design.

## Interface
Parameters:
- CH, 4, number of channels (1..16)
- W, 8, width of captured data
- SYNC, 2, synchroniser stages per input (1..4)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- sig  input  CH  event lines, may be asynchronous to clk
- mode  input  2*CH  per-channel edge select, channel i at bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- din  input  W  shared data bus, sampled on detected edges
- clr  input  CH  per-channel clear of pending and overrun
- pulse  output  CH  one-cycle strobe per detected edge
- pending  output  CH  sticky "edge captured, not yet cleared"
- overrun  output  CH  sticky "edge arrived while pending already set"
- cap_data  output  CH*W  per-channel captured din, channel i at bits [W*i+W-1:W*i]

## Operation
- Synchroniser: per channel, a SYNC-deep flop chain (s[0..SYNC-1]) followed by a history flop h.
- Edge terms on the synchronised output s[SYNC-1] versus h:
  - rise = s & ~h
  - fall = ~s & h
  - edge = (mode[0] & rise) | (mode[1] & fall)
- mode is evaluated combinationally each cycle. Changing mode never creates an edge on its own; only a change of s relative to h does.
- Arming counter:
  - After reset release, a counter runs SYNC+1 cycles. Edge detection is forced off until it saturates.
  - This prevents a line that is already high at reset from producing a spurious rising edge.
  - While disarmed, the synchroniser and h still track sig.
- On edge in cycle t, the following all appear at the next rising edge:
  - pulse = 1 for exactly one cycle
  - cap_data = din as sampled in cycle t
  - pending = 1
- A new edge while pending = 1:
  - cap_data is overwritten with the new din (latest wins).
  - overrun is set; pulse still fires.
- clr[i] = 1 with no edge on channel i: pending and overrun clear next cycle; cap_data is held.
- clr[i] and an edge in the same cycle:
  - The edge wins: pending = 1, cap_data updated, pulse = 1.
  - overrun is cleared to 0 (the previous event is considered consumed).
- Channels are fully independent; simultaneous edges on any subset are all captured.
- Reset values (rst_n = 0 at a rising edge):
  - all synchroniser and h flops 0
  - pulse = 0, pending = 0, overrun = 0, cap_data = 0
  - arming counter = 0
- Reset asserted mid-operation discards all pending state at that clock edge and restarts arming.

## Timing
- sig transition (meeting setup) to pulse high: SYNC+1 clk edges. This is 3 cycles at SYNC = 2.
- pulse width: exactly 1 cycle per edge.
  - A sig toggling with period ≥ 2 cycles under mode 11 yields one pulse per transition.
  - Toggles faster than the synchroniser can resolve may be lost; this is accepted.
- Latency from pulse to pending / cap_data valid: 0. They change on the same edge as pulse.
- clr to pending low: 1 cycle.
- First cycle an edge can be reported after rst_n rises: cycle SYNC+2.

## Test plan
- Reset with sig = 4'b1111 held, mode all 01, then release → no pulse, pending = 0 for 20 cycles; all outputs 0 during reset.
- Channel 0, mode 01, din = 8'hA5, sig[0] 0→1 → pulse[0] high exactly one cycle, 3 cycles after the change; cap_data[7:0] = A5; pending[0] = 1; other channels unaffected. Then sig[0] 1→0 → no pulse.
- Channel 1, mode 11, sig[1] toggled every 4 cycles four times → four pulses; cap_data tracks din at each pulse; after the second edge without clr, overrun[1] = 1.
- Channel 2: clr[2] asserted in the same cycle as a detected edge with din = 8'h3C → pending[2] = 1, overrun[2] = 0, cap_data = 3C. Then clr alone → pending[2] = 0 and cap_data still 3C.
- All channels edge simultaneously with mixed modes 00/01/10/11 → pulses only on channels whose mode matches the edge direction; each captures the same din.
- rst_n pulled low for one cycle while pending = 4'b1111 and overrun set → all flags 0 next cycle; no edge reported for SYNC+1 cycles afterwards.
